hcu_md: RTL and testbench

- Hazard control unit for the 5-stage pipeline (F/D/E/M/W), extended for P6.
- Generalised Tuse/Tnew stall detection with parametrised widths.
- Adds an E->D forwarding path and a sequential multiply/divide busy tracker that stalls HI/LO-related instructions in D.
- Sits beside the datapath and drives the stall/enable/flush and forwarding-mux selects.

---
 rtl/hcu_md_if.sv | 63 ++++++
 rtl/hcu_md.sv | 112 +++++++++++
 tb/tb_hcu_md.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hcu_md_if.sv
// rtl/hcu_md_if.sv - hazard control unit bus: stage addresses/timing in, stall and forward selects out
interface hcu_md_if #(
  parameter int AW          = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [TW-1:0] Tuse_rs;
  logic [TW-1:0] Tuse_rt;
  logic [TW-1:0] E_Tnew;
  logic [TW-1:0] M_Tnew;
  logic          E_RegWrite;
  logic          M_RegWrite;
  logic          W_RegWrite;
  logic [AW-1:0] D_A1;
  logic [AW-1:0] D_A2;
  logic [AW-1:0] E_A1;
  logic [AW-1:0] E_A2;
  logic [AW-1:0] E_A3;
  logic [AW-1:0] M_A2;
  logic [AW-1:0] M_A3;
  logic [AW-1:0] W_A3;
  logic          D_md_use;
  logic          E_md_start;
  logic          E_md_is_div;

  logic          stall;
  logic          F_en;
  logic          D_en;
  logic          E_clr;
  logic [1:0]    cmp1_Fwd;
  logic [1:0]    cmp2_Fwd;
  logic [1:0]    ALUa_Fwd;
  logic [1:0]    ALUb_Fwd;
  logic          DM_Fwd;
  logic          md_busy;
  logic [CW-1:0] md_count;

  // datapath side: drives pipeline state, consumes controls
  modport master (
    output Tuse_rs, Tuse_rt, E_Tnew, M_Tnew,
    output E_RegWrite, M_RegWrite, W_RegWrite,
    output D_A1, D_A2, E_A1, E_A2, E_A3, M_A2, M_A3, W_A3,
    output D_md_use, E_md_start, E_md_is_div,
    input  stall, F_en, D_en, E_clr,
    input  cmp1_Fwd, cmp2_Fwd, ALUa_Fwd, ALUb_Fwd, DM_Fwd,
    input  md_busy, md_count
  );

  // hazard unit side
  modport slave (
    input  Tuse_rs, Tuse_rt, E_Tnew, M_Tnew,
    input  E_RegWrite, M_RegWrite, W_RegWrite,
    input  D_A1, D_A2, E_A1, E_A2, E_A3, M_A2, M_A3, W_A3,
    input  D_md_use, E_md_start, E_md_is_div,
    output stall, F_en, D_en, E_clr,
    output cmp1_Fwd, cmp2_Fwd, ALUa_Fwd, ALUb_Fwd, DM_Fwd,
    output md_busy, md_count
  );
endinterface

// File: rtl/hcu_md.sv
// rtl/hcu_md.sv - Tuse/Tnew stall, E/M/W forwarding and mult/div busy tracking; HCU_STALL_CNT_EN adds stall_cnt
module hcu_md #(
  parameter int AW          = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  hcu_md_if.slave     bus
`ifdef HCU_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] r_md_count;

  // register-address match against a producing stage; $0 never matches
  logic w_d1_e, w_d1_m, w_d1_w;
  logic w_d2_e, w_d2_m, w_d2_w;
  logic w_e1_m, w_e1_w, w_e2_m, w_e2_w;
  logic w_m2_w;

  assign w_d1_e = (bus.D_A1 == bus.E_A3) && (bus.D_A1 != '0) && bus.E_RegWrite;
  assign w_d1_m = (bus.D_A1 == bus.M_A3) && (bus.D_A1 != '0) && bus.M_RegWrite;
  assign w_d1_w = (bus.D_A1 == bus.W_A3) && (bus.D_A1 != '0) && bus.W_RegWrite;
  assign w_d2_e = (bus.D_A2 == bus.E_A3) && (bus.D_A2 != '0) && bus.E_RegWrite;
  assign w_d2_m = (bus.D_A2 == bus.M_A3) && (bus.D_A2 != '0) && bus.M_RegWrite;
  assign w_d2_w = (bus.D_A2 == bus.W_A3) && (bus.D_A2 != '0) && bus.W_RegWrite;
  assign w_e1_m = (bus.E_A1 == bus.M_A3) && (bus.E_A1 != '0) && bus.M_RegWrite;
  assign w_e1_w = (bus.E_A1 == bus.W_A3) && (bus.E_A1 != '0) && bus.W_RegWrite;
  assign w_e2_m = (bus.E_A2 == bus.M_A3) && (bus.E_A2 != '0) && bus.M_RegWrite;
  assign w_e2_w = (bus.E_A2 == bus.W_A3) && (bus.E_A2 != '0) && bus.W_RegWrite;
  assign w_m2_w = (bus.M_A2 == bus.W_A3) && (bus.M_A2 != '0) && bus.W_RegWrite;

  // a producer stalls D when its result arrives later than the operand is needed;
  // an all-ones Tuse (operand unused) is never exceeded by a legal Tnew
  logic w_stall_rs, w_stall_rt, w_data_stall, w_md_busy, w_md_stall, w_stall;

  assign w_stall_rs   = (w_d1_e && (bus.E_Tnew > bus.Tuse_rs)) ||
                        (w_d1_m && (bus.M_Tnew > bus.Tuse_rs));
  assign w_stall_rt   = (w_d2_e && (bus.E_Tnew > bus.Tuse_rt)) ||
                        (w_d2_m && (bus.M_Tnew > bus.Tuse_rt));
  assign w_data_stall = w_stall_rs || w_stall_rt;
  assign w_md_busy    = (r_md_count != '0);
  assign w_md_stall   = bus.D_md_use && (bus.E_md_start || w_md_busy);
  assign w_stall      = reset && (w_data_stall || w_md_stall);

  // busy-window counter: a new start always reloads, otherwise count down to zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_md_count <= '0;
    end else if (bus.E_md_start) begin
      r_md_count <= bus.E_md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (r_md_count != '0) begin
      r_md_count <= r_md_count - 1'b1;
    end
  end

  // stall-derived controls and forwarding selects; everything idles while in reset
  always_comb begin
    bus.stall    = w_stall;
    bus.F_en     = ~w_stall;
    bus.D_en     = ~w_stall;
    bus.E_clr    = w_stall;
    bus.cmp1_Fwd = 2'b00;
    bus.cmp2_Fwd = 2'b00;
    bus.ALUa_Fwd = 2'b00;
    bus.ALUb_Fwd = 2'b00;
    bus.DM_Fwd   = 1'b0;
    bus.md_busy  = 1'b0;
    bus.md_count = '0;
    if (reset) begin
      if (w_d1_e && (bus.E_Tnew == '0))      bus.cmp1_Fwd = 2'b11;
      else if (w_d1_m && (bus.M_Tnew == '0)) bus.cmp1_Fwd = 2'b10;
      else if (w_d1_w)                       bus.cmp1_Fwd = 2'b01;

      if (w_d2_e && (bus.E_Tnew == '0))      bus.cmp2_Fwd = 2'b11;
      else if (w_d2_m && (bus.M_Tnew == '0)) bus.cmp2_Fwd = 2'b10;
      else if (w_d2_w)                       bus.cmp2_Fwd = 2'b01;

      if (w_e1_m && (bus.M_Tnew == '0))      bus.ALUa_Fwd = 2'b10;
      else if (w_e1_w)                       bus.ALUa_Fwd = 2'b01;

      if (w_e2_m && (bus.M_Tnew == '0))      bus.ALUb_Fwd = 2'b10;
      else if (w_e2_w)                       bus.ALUb_Fwd = 2'b01;

      bus.DM_Fwd   = w_m2_w;
      bus.md_busy  = w_md_busy;
      bus.md_count = r_md_count;
    end
  end

`ifdef HCU_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hcu_md.sv
// tb/tb_hcu_md.sv - directed scoreboard bench for hcu_md
module tb_hcu_md;
  logic clk;
  logic reset;

  hcu_md_if bus ();

`ifdef HCU_STALL_CNT_EN
  logic [31:0] stall_cnt;
  hcu_md dut (.clk(clk), .reset(reset), .bus(bus), .stall_cnt(stall_cnt));
`else
  hcu_md dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    S_STALL, S_FEN, S_DEN, S_ECLR, S_CMP1, S_CMP2, S_ALUA, S_ALUB, S_DM, S_BUSY, S_CNT, S_SCNT
  } sig_e;

  typedef struct {
    string       tag;
    sig_e        id;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_pass;
  int   n_fail;
  int   n_total;

  function automatic logic [31:0] get_obs(sig_e id);
    case (id)
      S_STALL: return {31'b0, bus.stall};
      S_FEN:   return {31'b0, bus.F_en};
      S_DEN:   return {31'b0, bus.D_en};
      S_ECLR:  return {31'b0, bus.E_clr};
      S_CMP1:  return {30'b0, bus.cmp1_Fwd};
      S_CMP2:  return {30'b0, bus.cmp2_Fwd};
      S_ALUA:  return {30'b0, bus.ALUa_Fwd};
      S_ALUB:  return {30'b0, bus.ALUb_Fwd};
      S_DM:    return {31'b0, bus.DM_Fwd};
      S_BUSY:  return {31'b0, bus.md_busy};
      S_CNT:   return 32'(bus.md_count);
`ifdef HCU_STALL_CNT_EN
      S_SCNT:  return stall_cnt;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic ex(input string tag, input sig_e id, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.id  = id;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (q.size() > 0) begin
      e   = q.pop_front();
      obs = get_obs(e.id);
      n_total++;
      assert (obs === e.val) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.Tuse_rs     = 2'b11;
    bus.Tuse_rt     = 2'b11;
    bus.E_Tnew      = 2'd0;
    bus.M_Tnew      = 2'd0;
    bus.E_RegWrite  = 1'b0;
    bus.M_RegWrite  = 1'b0;
    bus.W_RegWrite  = 1'b0;
    bus.D_A1        = '0;
    bus.D_A2        = '0;
    bus.E_A1        = '0;
    bus.E_A2        = '0;
    bus.E_A3        = '0;
    bus.M_A2        = '0;
    bus.M_A3        = '0;
    bus.W_A3        = '0;
    bus.D_md_use    = 1'b0;
    bus.E_md_start  = 1'b0;
    bus.E_md_is_div = 1'b0;
  endtask

  task automatic set_lw_stall();
    bus.E_Tnew     = 2'd2;
    bus.E_A3       = 5'd3;
    bus.E_RegWrite = 1'b1;
    bus.Tuse_rs    = 2'd0;
    bus.D_A1       = 5'd3;
  endtask

  initial begin
    n_pass  = 0;
    n_fail  = 0;
    n_total = 0;
    reset   = 1'b0;
    clr();

    // reset held with every hazard/forward condition active: outputs idle
    set_lw_stall();
    bus.D_md_use   = 1'b1;
    bus.E_md_start = 1'b1;
    bus.E_A1 = 5'd5; bus.M_A3 = 5'd5; bus.M_RegWrite = 1'b1;
    bus.M_A2 = 5'd7; bus.W_A3 = 5'd7; bus.W_RegWrite = 1'b1;
    cyc();
    cyc();
    ex("rst_stall", S_STALL, 0); ex("rst_fen", S_FEN, 1); ex("rst_den", S_DEN, 1);
    ex("rst_eclr", S_ECLR, 0); ex("rst_alua", S_ALUA, 0); ex("rst_dm", S_DM, 0);
    ex("rst_cmp1", S_CMP1, 0); ex("rst_busy", S_BUSY, 0); ex("rst_cnt", S_CNT, 0);
`ifdef HCU_STALL_CNT_EN
    ex("rst_scnt", S_SCNT, 0);
`endif
    drain();

    // lw in E, beq on the same register in D
    reset = 1'b1;
    clr();
    set_lw_stall();
    #1;
    ex("lw_stall", S_STALL, 1); ex("lw_eclr", S_ECLR, 1); ex("lw_fen", S_FEN, 0); ex("lw_den", S_DEN, 0);
    drain();
    bus.D_A1 = 5'd0;
    #1;
    ex("lw_r0_nostall", S_STALL, 0); ex("lw_r0_fen", S_FEN, 1);
    drain();
    bus.D_A1 = 5'd3; bus.Tuse_rs = 2'b11;
    #1;
    ex("tuse_unused", S_STALL, 0);
    drain();
    bus.Tuse_rs = 2'd2;
    #1;
    ex("tnew_eq_tuse", S_STALL, 0);
    drain();
    clr();
    bus.M_A3 = 5'd4; bus.M_Tnew = 2'd1; bus.M_RegWrite = 1'b1; bus.D_A2 = 5'd4; bus.Tuse_rt = 2'd0;
    #1;
    ex("m_rt_stall", S_STALL, 1);
    drain();

    // jal in E, jr $31 in D
    clr();
    bus.E_Tnew = 2'd0; bus.E_A3 = 5'd31; bus.E_RegWrite = 1'b1;
    bus.D_A1 = 5'd31; bus.Tuse_rs = 2'd0;
    #1;
    ex("jal_nostall", S_STALL, 0); ex("jal_cmp1_e", S_CMP1, 3);
    drain();
    bus.M_A3 = 5'd31; bus.M_Tnew = 2'd0; bus.M_RegWrite = 1'b1; bus.D_A2 = 5'd31; bus.Tuse_rt = 2'd0;
    #1;
    ex("cmp1_e_over_m", S_CMP1, 3); ex("cmp2_e_over_m", S_CMP2, 3);
    drain();
    bus.E_RegWrite = 1'b0;
    #1;
    ex("cmp1_m", S_CMP1, 2);
    drain();
    bus.M_RegWrite = 1'b0; bus.W_A3 = 5'd31; bus.W_RegWrite = 1'b1;
    #1;
    ex("cmp1_w", S_CMP1, 1); ex("cmp2_w", S_CMP2, 1);
    drain();

    // ALU and DM forwarding
    clr();
    bus.E_A1 = 5'd5; bus.M_A3 = 5'd5; bus.M_Tnew = 2'd0; bus.M_RegWrite = 1'b1;
    bus.W_A3 = 5'd5; bus.W_RegWrite = 1'b1;
    #1;
    ex("alua_m", S_ALUA, 2); ex("alub_none", S_ALUB, 0);
    drain();
    bus.M_RegWrite = 1'b0;
    #1;
    ex("alua_w", S_ALUA, 1);
    drain();
    clr();
    bus.E_A2 = 5'd0; bus.W_A3 = 5'd0; bus.W_RegWrite = 1'b1; bus.M_A2 = 5'd7;
    #1;
    ex("alub_r0", S_ALUB, 0); ex("dm_none", S_DM, 0);
    drain();
    bus.W_A3 = 5'd7;
    #1;
    ex("dm_w", S_DM, 1);
    drain();

    // mult start with mflo waiting in D
    clr();
    bus.D_md_use = 1'b1; bus.E_md_start = 1'b1; bus.E_md_is_div = 1'b0;
    #1;
    ex("mult_start_stall", S_STALL, 1); ex("mult_start_cnt", S_CNT, 0);
    drain();
    for (int n = 5; n >= 1; n--) begin
      cyc();
      bus.E_md_start = 1'b0;
      #1;
      ex("mult_cnt", S_CNT, 32'(n)); ex("mult_busy", S_BUSY, 1); ex("mult_stall", S_STALL, 1);
      drain();
    end
    cyc();
    ex("mult_done_cnt", S_CNT, 0); ex("mult_done_busy", S_BUSY, 0); ex("mult_done_stall", S_STALL, 0);
    drain();

    // div window
    bus.E_md_start = 1'b1; bus.E_md_is_div = 1'b1;
    for (int n = 10; n >= 1; n--) begin
      cyc();
      bus.E_md_start = 1'b0;
      #1;
      ex("div_cnt", S_CNT, 32'(n)); ex("div_stall", S_STALL, 1);
      drain();
    end
    cyc();
    ex("div_done_stall", S_STALL, 0); ex("div_done_busy", S_BUSY, 0);
    drain();

    // mult started, reloaded by div while busy, then reset mid-window
    bus.E_md_start = 1'b1; bus.E_md_is_div = 1'b0;
    cyc();
    ex("reload_mult_cnt", S_CNT, 5);
    drain();
    bus.E_md_is_div = 1'b1;
    cyc();
    bus.E_md_start = 1'b0;
    #1;
    ex("reload_div_cnt", S_CNT, 10);
    drain();
    for (int k = 0; k < 4; k++) cyc();
    ex("pre_reset_cnt", S_CNT, 6);
    drain();
    reset = 1'b0;
    #1;
    ex("inrst_stall", S_STALL, 0); ex("inrst_busy", S_BUSY, 0); ex("inrst_fen", S_FEN, 1);
    drain();
    cyc();
    reset = 1'b1;
    #1;
    ex("rel_cnt", S_CNT, 0); ex("rel_busy", S_BUSY, 0); ex("rel_stall", S_STALL, 0);
    drain();

    // three data-stall cycles, then a mult window with D_md_use: 3 + 1 + 5 stalled cycles
    clr();
    set_lw_stall();
    cyc(); cyc(); cyc();
    clr();
    bus.D_md_use = 1'b1; bus.E_md_start = 1'b1;
    cyc();
    bus.E_md_start = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    #1;
    ex("post_window_stall", S_STALL, 0);
`ifdef HCU_STALL_CNT_EN
    ex("stall_cnt_9", S_SCNT, 9);
`endif
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
